// File: rtl/obs_pkg.sv
// ---------------------------------------------------------------------------
// obs_pkg
// Shared definitions for the OBS overlap collector family.
//   SLOT_P1..SLOT_P4 : 2-bit tags that name the four sub-products of one level
//   state_t          : collector FSM states (COLLECT gathers beats, HOLD
//                      presents the combined product until it is taken)
// ---------------------------------------------------------------------------
package obs_pkg;

    localparam logic [1:0] SLOT_P1 = 2'd0;
    localparam logic [1:0] SLOT_P2 = 2'd1;
    localparam logic [1:0] SLOT_P3 = 2'd2;
    localparam logic [1:0] SLOT_P4 = 2'd3;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/obs_overlap_spread.sv
// ---------------------------------------------------------------------------
// obs_overlap_spread
// Purely combinational scatter of one (N-1)-bit sub-product into the
// 2N-1 bit product space, according to which slot it belongs to.
//   i_sel    : slot tag (SLOT_P1..SLOT_P4)
//   i_data   : sub-product bits d[0..N-2]
//   o_spread : scattered value, all bits not written by the slot are 0
//                P1 -> bit 2i, P2/P3 -> bit 2i+1, P4 -> bit 2i+2
// ---------------------------------------------------------------------------
module obs_overlap_spread
    import obs_pkg::*;
#(
    parameter int N = 52
) (
    input  logic [1:0]   i_sel,
    input  logic [N-2:0] i_data,
    output logic [2*N-2:0] o_spread
);

    // P2 and P3 both land on the odd positions; the collector XORs them in,
    // which is exactly the GF(2) sum the overlap step needs.
    always_comb begin
        o_spread = '0;
        for (int i = 0; i < N - 1; i++) begin
            case (i_sel)
                SLOT_P1: o_spread[2*i]     = i_data[i];
                SLOT_P4: o_spread[2*i + 2] = i_data[i];
                default: o_spread[2*i + 1] = i_data[i];
            endcase
        end
    end

endmodule

// File: rtl/obs_overlap_collect.sv
// ---------------------------------------------------------------------------
// obs_overlap_collect
// Serially gathers the four GF(2) sub-products of one OBS level, XOR-scatters
// them into a 2N-1 bit accumulator and presents the combined product once all
// four slots have been seen, so a single time-shared multiplier core can feed
// a whole level.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   flush     : synchronous abort of the frame in progress (highest priority)
//   in_valid / in_ready / in_sel / in_data : beat input, slot-tagged
//   out_valid / out_ready / out_data       : combined product output
//   dup_err   : sticky flag, a slot arrived twice within one frame
// ---------------------------------------------------------------------------
module obs_overlap_collect
    import obs_pkg::*;
#(
    parameter int N = 52
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_sel,
    input  logic [N-2:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] out_data,
    output logic           dup_err
);

    state_t         r_state;
    logic [2*N-2:0] r_acc;
    logic [3:0]     r_mask;
    logic           r_outValid;
    logic [2*N-2:0] r_outData;
    logic           r_dupErr;

    logic [2*N-2:0] w_spread;
    logic [2*N-2:0] w_accNext;
    logic [3:0]     w_selBit;
    logic [3:0]     w_maskNext;
    logic           w_accept;
    logic           w_isDup;

    obs_overlap_spread #(
        .N(N)
    ) u_spread (
        .i_sel    (in_sel),
        .i_data   (in_data),
        .o_spread (w_spread)
    );

    // in_ready depends on state only, so there is no path from in_valid.
    assign in_ready  = (r_state == COLLECT);
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign dup_err   = r_dupErr;

    assign w_accept   = in_valid & in_ready;
    assign w_selBit   = 4'b0001 << in_sel;
    assign w_isDup    = |(r_mask & w_selBit);
    assign w_maskNext = r_mask | w_selBit;
    assign w_accNext  = r_acc ^ w_spread;

    // Collector FSM. out_data is kept in its own register so the last result
    // stays visible after the handshake and only moves on the next completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= COLLECT;
            r_acc      <= '0;
            r_mask     <= '0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_dupErr   <= 1'b0;
        end else if (flush) begin
            // Any beat presented alongside flush is discarded, and a pending
            // result is dropped without a handshake.
            r_state    <= COLLECT;
            r_acc      <= '0;
            r_mask     <= '0;
            r_outValid <= 1'b0;
            r_dupErr   <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        if (w_isDup) begin
                            // Consume the beat but keep the first copy only.
                            r_dupErr <= 1'b1;
                        end else begin
                            r_acc  <= w_accNext;
                            r_mask <= w_maskNext;
                            if (w_maskNext == 4'hF) begin
                                r_state    <= HOLD;
                                r_outValid <= 1'b1;
                                r_outData  <= w_accNext;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state    <= COLLECT;
                        r_acc      <= '0;
                        r_mask     <= '0;
                        r_outValid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

endmodule
